dram_timing_ctrl: RTL and testbench
===================================

Name: dram_timing_ctrl

Overview:
- Timing-controller end of the DRAM command/timing handshake; drives `timing_signals_if` through its `timing_ctrl` modport (`tACT_done`, `tWR_done`, `tRD_done`, `tPRE_done`, `tREF_done`, `rf_req`).
- Observes one-cycle command-issue pulses from the command FSM and runs an independent countdown per command class; each `*_done` marks the cycle the constraint is met.
- A free-running refresh-interval counter raises `rf_req`, held until the FSM issues REF.

Parameters:
- T_ACT, 4, cycles from ACT issue to `tACT_done` (tRCD); legal range ≥1.
- T_WR, 6, cycles from WR issue to `tWR_done` (write latency + burst + write recovery); ≥1.
- T_RD, 5, cycles from RD issue to `tRD_done` (CAS latency + burst); ≥1.
- T_PRE, 4, cycles from PRE issue to `tPRE_done` (tRP); ≥1.
- T_REF, 20, cycles from REF issue to `tREF_done` (tRFC); ≥1.
- T_REFI, 200, refresh interval in cycles; ≥2.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- cmd_act  in  1  ACT issued this cycle (1-cycle pulse)
- cmd_wr  in  1  WR issued this cycle
- cmd_rd  in  1  RD issued this cycle
- cmd_pre  in  1  PRE issued this cycle
- cmd_ref  in  1  REF issued this cycle
- tACT_done  out  1  ACT timing satisfied (1-cycle pulse)
- tWR_done  out  1  WR timing satisfied (pulse)
- tRD_done  out  1  RD timing satisfied (pulse)
- tPRE_done  out  1  PRE timing satisfied (pulse)
- tREF_done  out  1  REF timing satisfied (pulse)
- rf_req  out  1  refresh required (level, held until serviced)

Behaviour:
- Reset: sampled on CLK rising edge when nRST=0.
  - All `*_done`=0, `rf_req`=0, all countdowns IDLE, refresh-interval counter=0.
  - Reset mid-count aborts every countdown; no late done pulse follows.
- Per-command countdown, 5 identical instances. Each has states IDLE and COUNT.
  - Counter width is $clog2(T_x+1).
  - IDLE→COUNT on cmd_x=1: load T_x-1.
  - COUNT: decrement each cycle. At count==0, assert done_x for exactly that one cycle and return to IDLE.
  - Latency: cmd_x registered at edge k → done_x high during cycle k+T_x. T_x=1 gives done the next cycle.
  - done_x is registered, never combinational from cmd_x.
  - cmd_x while COUNT: reload T_x-1 (restart); the in-flight done is discarded.
  - cmd_x in the same cycle done_x is high: done_x still pulses this cycle, and the new countdown starts.
  - Instances are fully independent; simultaneous commands to different classes are legal and each times separately.
- Refresh interval:
  - Counter runs continuously from reset, 0..T_REFI-1, then wraps to 0.
  - It is not paused by REF or any other command.
  - On the cycle the counter wraps (value T_REFI-1 → 0), `rf_req` is set to 1 at the next edge.
  - `rf_req` clears at the edge after cmd_ref=1.
  - Wrap and cmd_ref in the same cycle: set wins; `rf_req` stays 1, because a new interval has elapsed.
  - Further wraps while `rf_req`=1 change nothing: no counting of missed refreshes.
  - First `rf_req` rises at cycle T_REFI after reset deassertion.
  - cmd_ref with `rf_req`=0 (early refresh) is legal: it starts the T_REF countdown and leaves `rf_req` at 0.
- No illegal-input checks: the FSM is responsible for command legality.

Test Plan:
- Reset: hold nRST=0 for 3 cycles with cmd_act=1 → all outputs 0 throughout; after release, first `rf_req` rises exactly 200 cycles later.
- Basic latency: cmd_act pulse at cycle 10 → `tACT_done`=1 only at cycle 14. Repeat for the other classes: WR→16, RD→15, PRE→14, REF→30.
- Retrigger: cmd_rd at 10, again at 12 → no pulse at 15; single `tRD_done` at 17.
- Concurrency: cmd_act and cmd_pre both at cycle 5, cmd_wr at 6 → `tACT_done`@9, `tPRE_done`@9, `tWR_done`@12, each exactly 1 cycle wide.
- Refresh handshake: wait for `rf_req`=1 (cycle 200), issue cmd_ref at 210 → `rf_req` drops at 211, `tREF_done`@230, next `rf_req` at 400. Separately, leave `rf_req` unserviced across the 400 wrap → stays 1, single clear on one cmd_ref.
- Collision: cmd_ref issued exactly on the wrap cycle (counter=199) → `rf_req` remains 1 after the edge; mid-count reset at cycle 12 after cmd_wr at 10 → no `tWR_done` ever appears.

Source files
------------

// File: rtl/dram_timing_ctrl.sv
// DRAM timing controller: per-command countdowns that pulse *_done when a
// constraint is met, plus a free-running refresh-interval request.

module dram_timing_cnt #(
  parameter int unsigned T = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic cmd,
  output logic done
);

  localparam int unsigned W = $clog2(T + 1);
  localparam logic [W-1:0] LOAD = W'(T - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [0:0]   state, state_d;
  logic [W-1:0] cnt, cnt_d;
  logic         done_d;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      done  <= done_d;
    end
  end

  // done is registered alongside the state it decodes: high while COUNT holds zero
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (cmd) begin
          state_d = COUNT;
          cnt_d   = LOAD;
        end
      end
      COUNT: begin
        if (cmd) begin
          cnt_d = LOAD;
        end else if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == COUNT) && (cnt_d == '0);
  end

endmodule

module dram_timing_ctrl #(
  parameter int unsigned T_ACT  = 4,
  parameter int unsigned T_WR   = 6,
  parameter int unsigned T_RD   = 5,
  parameter int unsigned T_PRE  = 4,
  parameter int unsigned T_REF  = 20,
  parameter int unsigned T_REFI = 200
) (
  input  logic CLK,
  input  logic nRST,
  input  logic cmd_act,
  input  logic cmd_wr,
  input  logic cmd_rd,
  input  logic cmd_pre,
  input  logic cmd_ref,
  output logic tACT_done,
  output logic tWR_done,
  output logic tRD_done,
  output logic tPRE_done,
  output logic tREF_done,
  output logic rf_req
);

  localparam int unsigned RW = $clog2(T_REFI);
  localparam logic [RW-1:0] REFI_LAST = RW'(T_REFI - 1);

  logic [RW-1:0] refi_cnt, refi_cnt_d;
  logic          rf_req_d;

  dram_timing_cnt #(.T(T_ACT)) u_act (.CLK(CLK), .nRST(nRST), .cmd(cmd_act), .done(tACT_done));
  dram_timing_cnt #(.T(T_WR))  u_wr  (.CLK(CLK), .nRST(nRST), .cmd(cmd_wr),  .done(tWR_done));
  dram_timing_cnt #(.T(T_RD))  u_rd  (.CLK(CLK), .nRST(nRST), .cmd(cmd_rd),  .done(tRD_done));
  dram_timing_cnt #(.T(T_PRE)) u_pre (.CLK(CLK), .nRST(nRST), .cmd(cmd_pre), .done(tPRE_done));
  dram_timing_cnt #(.T(T_REF)) u_ref (.CLK(CLK), .nRST(nRST), .cmd(cmd_ref), .done(tREF_done));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      refi_cnt <= '0;
      rf_req   <= 1'b0;
    end else begin
      refi_cnt <= refi_cnt_d;
      rf_req   <= rf_req_d;
    end
  end

  // A wrap outranks a same-cycle REF: a fresh interval has just elapsed
  always_comb begin
    refi_cnt_d = refi_cnt + RW'(1);
    rf_req_d   = rf_req;
    if (refi_cnt == REFI_LAST) begin
      refi_cnt_d = '0;
      rf_req_d   = 1'b1;
    end else if (cmd_ref) begin
      rf_req_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// Directed bench for dram_timing_ctrl with a cycle-numbered deadline model.

module tb_dram_timing_ctrl;

  localparam int T_REFI = 200;
  localparam int TV [5] = '{4, 6, 5, 4, 20};  // act, wr, rd, pre, ref
  localparam logic [4:0] ACT = 5'b00001, WR = 5'b00010, RD = 5'b00100,
                         PRE = 5'b01000, REF = 5'b10000;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [4:0] cmds = '0;
  logic t_act, t_wr, t_rd, t_pre, t_ref, rf_req;
  logic [4:0] dn;

  int total = 0;
  int bad = 0;

  // Model: cycle n = n edges after the last reset edge
  int cyc = 0;
  int dl [5] = '{-1, -1, -1, -1, -1};
  bit m_rf = 1'b0;
  bit live = 1'b0;

  dram_timing_ctrl #(
    .T_ACT(4), .T_WR(6), .T_RD(5), .T_PRE(4), .T_REF(20), .T_REFI(200)
  ) dut (
    .CLK(clk), .nRST(nrst),
    .cmd_act(cmds[0]), .cmd_wr(cmds[1]), .cmd_rd(cmds[2]),
    .cmd_pre(cmds[3]), .cmd_ref(cmds[4]),
    .tACT_done(t_act), .tWR_done(t_wr), .tRD_done(t_rd),
    .tPRE_done(t_pre), .tREF_done(t_ref), .rf_req(rf_req)
  );

  assign dn = {t_ref, t_pre, t_rd, t_wr, t_act};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!nrst) begin
      cyc  <= 0;
      m_rf <= 1'b0;
      live <= 1'b1;
      for (int i = 0; i < 5; i++) dl[i] <= -1;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 5; i++) if (cmds[i]) dl[i] <= cyc + TV[i];
      if (cyc % T_REFI == T_REFI - 1) m_rf <= 1'b1;
      else if (cmds[4]) m_rf <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (dn[i] !== (dl[i] == cyc)) begin
          bad++;
          $display("FAIL model_done[%0d] cyc=%0d got=%b want=%b", i, cyc, dn[i], (dl[i] == cyc));
        end
      end
      total++;
      if (rf_req !== m_rf) begin
        bad++;
        $display("FAIL model_rf_req cyc=%0d got=%b want=%b", cyc, rf_req, m_rf);
      end
    end
  end

  task automatic chk(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
    end
  endtask

  task automatic go(input int n);
    int guard = 0;
    while (cyc != n && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      total++;
      bad++;
      $display("FAIL goto_timeout target=%0d got=%0d", n, cyc);
    end
  endtask

  task automatic pulse(input logic [4:0] m, input int n);
    go(n);
    cmds = m;
    go(n + 1);
    cmds = '0;
  endtask

  task automatic do_reset(input int n, input logic [4:0] hold);
    nrst = 1'b0;
    cmds = hold;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("reset_outs_zero", |{dn, rf_req}, 1'b0);
    end
    nrst = 1'b1;
    cmds = '0;
  endtask

  initial begin
    #2;
    // Reset with ACT held, then the refresh handshake timeline
    do_reset(3, ACT);
    go(4);   chk("no_act_after_reset", t_act, 1'b0);
    go(199); chk("rf_req_199", rf_req, 1'b0);
    go(200); chk("rf_req_200", rf_req, 1'b1);
    pulse(REF, 210);
    chk("rf_req_cleared_211", rf_req, 1'b0);
    go(229); chk("tref_229", t_ref, 1'b0);
    go(230); chk("tref_230", t_ref, 1'b1);
    go(231); chk("tref_231", t_ref, 1'b0);
    go(399); chk("rf_req_399", rf_req, 1'b0);
    go(400); chk("rf_req_400", rf_req, 1'b1);
    go(601); chk("rf_req_held_601", rf_req, 1'b1);
    pulse(REF, 610);
    chk("rf_req_single_clear_611", rf_req, 1'b0);
    go(800); chk("rf_req_800", rf_req, 1'b1);
    pulse(REF, 999);
    chk("rf_req_wrap_wins_1000", rf_req, 1'b1);
    pulse(REF, 1010);
    chk("rf_req_clear_1011", rf_req, 1'b0);
    go(1019); chk("tref_restart_1019", t_ref, 1'b0);
    go(1030); chk("tref_restart_1030", t_ref, 1'b1);

    // Basic latency, all classes issued together; REF here is early
    do_reset(2, '0);
    pulse(ACT | WR | RD | PRE | REF, 10);
    chk("early_ref_no_rf_req", rf_req, 1'b0);
    go(13); chk("act_13", t_act, 1'b0);
    go(14); chk("act_14", t_act, 1'b1); chk("pre_14", t_pre, 1'b1);
    go(15); chk("rd_15", t_rd, 1'b1); chk("act_15", t_act, 1'b0);
    go(16); chk("wr_16", t_wr, 1'b1);
    go(30); chk("ref_30", t_ref, 1'b1);

    // Retrigger RD
    do_reset(2, '0);
    pulse(RD, 10);
    pulse(RD, 12);
    go(15); chk("rd_retrig_15", t_rd, 1'b0);
    go(17); chk("rd_retrig_17", t_rd, 1'b1);
    go(18); chk("rd_retrig_18", t_rd, 1'b0);

    // Concurrency, then a command landing on its own done cycle
    do_reset(2, '0);
    pulse(ACT | PRE, 5);
    pulse(WR, 6);
    go(9);  chk("conc_act_9", t_act, 1'b1); chk("conc_pre_9", t_pre, 1'b1);
    go(10); chk("conc_act_10", t_act, 1'b0);
    go(12); chk("conc_wr_12", t_wr, 1'b1);
    go(13); chk("conc_wr_13", t_wr, 1'b0);
    pulse(ACT, 20);
    go(24); chk("act_24", t_act, 1'b1);
    cmds = ACT;
    go(25); cmds = '0;
    go(28); chk("act_back_to_back_28", t_act, 1'b1);

    // Mid-count reset kills the WR countdown
    do_reset(2, '0);
    pulse(WR, 10);
    go(12);
    do_reset(1, '0);
    for (int k = 0; k < 12; k++) begin
      go(k + 1);
      chk("wr_aborted", t_wr, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
